// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and address/block geometry for the instruction cache
package icache_pkg;
  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int BLOCK_W = 128;
  localparam int OFFSET_W = 4;
  localparam int BLK_ADDR_W = ADDR_W - OFFSET_W;
endpackage

// File: rtl/icache_ctrl.sv
// icache_ctrl: refill FSM and latched block address for the instruction cache
module icache_ctrl
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_read,
  input  logic                  hit,
  input  logic                  mem_busywait,
  input  logic [BLK_ADDR_W-1:0] pc_block,
  output logic                  cache_busywait,
  output logic                  mem_read,
  output logic                  fill,
  output logic [BLK_ADDR_W-1:0] mem_address
);
  state_t state, next;
  logic miss;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      mem_address <= '0;
    end else begin
      state <= next;
      if (miss) mem_address <= pc_block;
    end
  end
  always_comb begin
    miss = state == IDLE && pc_read && !hit;
    mem_read = state == MEM_READ;
    fill = state == UPDATE;
    cache_busywait = miss || state != IDLE;
    next = state == IDLE ? (miss ? MEM_READ : IDLE) :
           state == MEM_READ ? (mem_busywait ? MEM_READ : UPDATE) : IDLE;
  end
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only cache, 16-byte blocks; ICACHE_PERF_COUNTERS_EN adds hit/miss counters
module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_read,
  input  logic [ADDR_W-1:0]     pc_address,
  output logic [WORD_W-1:0]     instruction,
  output logic                  cache_busywait,
  output logic                  mem_read,
  output logic [BLK_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int SETS = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_BITS;
  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [BLOCK_W-1:0] data [SETS];
  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic hit, fill, unused_byte_bits;
  assign idx = pc_address[OFFSET_W +: INDEX_BITS];
  assign tag = pc_address[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_address[INDEX_BITS-1:0];
  assign fill_tag = mem_address[BLK_ADDR_W-1 -: TAG_W];
  assign hit = pc_read & valid[idx] & (tags[idx] == tag);
  assign instruction = data[idx][{pc_address[3:2], 5'b0} +: WORD_W];
  assign unused_byte_bits = ^pc_address[1:0];
  icache_ctrl u_ctrl (
    .clk(clk),
    .reset(reset),
    .pc_read(pc_read),
    .hit(hit),
    .mem_busywait(mem_busywait),
    .pc_block(pc_address[ADDR_W-1:OFFSET_W]),
    .cache_busywait(cache_busywait),
    .mem_read(mem_read),
    .fill(fill),
    .mem_address(mem_address)
  );
  always_ff @(posedge clk) begin
    if (!reset) valid <= '0;
    else if (fill) valid[fill_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (fill && reset) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= mem_readdata;
    end
  end
`ifdef ICACHE_PERF_COUNTERS_EN
  // a hit only stalls nothing in IDLE; a miss start is the only busy cycle with neither mem_read nor fill
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (hit && !cache_busywait) hit_count <= hit_count + 32'd1;
      if (cache_busywait && !mem_read && !fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed fetches against a reference cache model with a latency-programmable memory
module tb_instruction_cache;
  logic clk = 1'b0, reset = 1'b0, pc_read = 1'b0, mem_busywait;
  logic [31:0] pc_address = '0, instruction;
  logic cache_busywait, mem_read;
  logic [27:0] mem_address;
  logic [127:0] mem_readdata;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int total = 0, bad = 0, lat = 5, cnt = 0, n;
  always #5 clk = ~clk;
  instruction_cache dut (
    .clk(clk),
    .reset(reset),
    .pc_read(pc_read),
    .pc_address(pc_address),
    .instruction(instruction),
    .cache_busywait(cache_busywait),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  function automatic logic [127:0] memdata(input logic [27:0] b);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = ({b, 4'b0} | 32'(i * 4)) ^ 32'hA5A50000;
    return d;
  endfunction
  assign mem_readdata = memdata(mem_address);
  assign mem_busywait = mem_read && cnt != lat - 1;
  always @(posedge clk) cnt <= mem_read ? cnt + 1 : 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [7:0] mvalid;
  logic [24:0] mtag [8];
  logic [27:0] mlast;
  logic [127:0] mblk;
  int left, mhits, mmiss;
  logic mhit;
  assign mhit = pc_read && mvalid[pc_address[6:4]] && mtag[pc_address[6:4]] == pc_address[31:7];
  // left counts the stalled refill cycles still to come: lat fetch cycles, then one write cycle
  always @(posedge clk) begin
    if (!reset) begin
      mvalid <= '0;
      left <= 0;
      mlast <= '0;
      mhits <= 0;
      mmiss <= 0;
    end else if (left == 0) begin
      if (mhit) mhits <= mhits + 1;
      else if (pc_read) begin
        left <= lat + 1;
        mlast <= pc_address[31:4];
        mmiss <= mmiss + 1;
      end
    end else begin
      if (left == 1) begin
        mvalid[mlast[2:0]] <= 1'b1;
        mtag[mlast[2:0]] <= mlast[27:3];
      end
      left <= left - 1;
    end
  end
  always @(negedge clk) begin
    if (reset) begin
      if (left == 0) begin
        chk("m_busy", 32'(cache_busywait), 32'(pc_read && !mhit));
        chk("m_memread", 32'(mem_read), 32'd0);
        if (mhit) begin
          mblk = memdata(pc_address[31:4]);
          chk("m_instr", instruction, mblk[{pc_address[3:2], 5'b0} +: 32]);
        end
      end else begin
        chk("m_busy", 32'(cache_busywait), 32'd1);
        chk("m_memread", 32'(mem_read), 32'(left > 1));
      end
      chk("m_memaddr", 32'(mem_address), 32'(mlast));
`ifdef ICACHE_PERF_COUNTERS_EN
      chk("m_hitcnt", hit_count, 32'(mhits));
      chk("m_misscnt", miss_count, 32'(mmiss));
`endif
    end
  end
  task automatic fetch(input logic [31:0] pc, output int cycles);
    bit done = 0;
    @(posedge clk); #1;
    pc_read = 1'b1;
    pc_address = pc;
    cycles = 0;
    while (!done && cycles < 60) begin
      @(negedge clk);
      if (!cache_busywait) done = 1;
      else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    if (!done) chk("fetch_timeout", 32'(cycles), 32'd0);
  endtask
  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    pc_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask
  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(cache_busywait), 32'd0);
    chk("rst_memread", 32'(mem_read), 32'd0);
    chk("rst_memaddr", 32'(mem_address), 32'd0);
    lat = 5;
    fetch(32'h0, n);
    chk("miss0_cycles", 32'(n), 32'd7);
    chk("miss0_instr", instruction, 32'hA5A50000);
    fetch(32'hC, n);
    chk("hitC_cycles", 32'(n), 32'd0);
    chk("hitC_instr", instruction, 32'hA5A5000C);
    fetch(32'h80, n);
    chk("miss80_cycles", 32'(n), 32'd7);
    chk("miss80_instr", instruction, 32'hA5A50080);
    fetch(32'h0, n);
    chk("remiss0_cycles", 32'(n), 32'd7);
    @(posedge clk); #1;
    pc_read = 1'b1;
    pc_address = 32'h100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_memread_on", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    pc_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_memread_off", 32'(mem_read), 32'd0);
    chk("abort_busy", 32'(cache_busywait), 32'd0);
    fetch(32'h100, n);
    chk("abort_refetch_cycles", 32'(n), 32'd7);
    lat = 3;
    @(posedge clk); #1;
    pc_read = 1'b1;
    pc_address = 32'h0;
    @(posedge clk); #1;
    pc_address = 32'h40;
    @(negedge clk);
    chk("mid_memaddr", 32'(mem_address), 32'd0);
    fetch(32'h40, n);
    chk("mid_cycles", 32'(n), 32'd8);
    chk("mid_instr", instruction, 32'hA5A50040);
    fetch(32'h0, n);
    chk("mid_blk0_hit", 32'(n), 32'd0);
    chk("mid_blk0_instr", instruction, 32'hA5A50000);
    lat = 1;
    fetch(32'hFFFFFFFC, n);
    chk("top_cycles", 32'(n), 32'd3);
    chk("top_instr", instruction, 32'h5A5AFFFC);
    fetch(32'hFFFFFFFF, n);
    chk("bytebits_cycles", 32'(n), 32'd0);
    chk("bytebits_instr", instruction, 32'h5A5AFFFC);
    @(posedge clk); #1;
    pc_read = 1'b0;
    pc_address = 32'h12340000;
    @(negedge clk);
    chk("noread_busy", 32'(cache_busywait), 32'd0);
    chk("noread_memread", 32'(mem_read), 32'd0);
`ifdef ICACHE_PERF_COUNTERS_EN
    lat = 2;
    pulse_reset();
    fetch(32'h0, n);
    fetch(32'h4, n);
    fetch(32'h8, n);
    fetch(32'h80, n);
    @(posedge clk); #1;
    pc_read = 1'b0;
    @(negedge clk);
    chk("perf_hits", hit_count, 32'd4);
    chk("perf_misses", miss_count, 32'd2);
`endif
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
